// File: rtl/vga_frame_timer_if.sv
// Pattern-generator timing bus: the frame timer is the master (source) end,
// pattern generators attach to the slave end.
interface vga_frame_timer_if;
    logic       pause;
    logic       step;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       next_frame;

    modport master (
        input  pause,
        input  step,
        output x,
        output y,
        output active,
        output hsync,
        output vsync,
        output next_frame
    );

    modport slave (
        output pause,
        output step,
        input  x,
        input  y,
        input  active,
        input  hsync,
        input  vsync,
        input  next_frame
    );
endinterface

// File: rtl/vga_frame_timer.sv
// VGA 640x480@60 frame timer with divided, pausable next_frame pulse.
// Optional single-frame step via `step` when FRAME_STEP_EN is defined.
module vga_frame_timer #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned FRAME_DIV = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_frame_timer_if.master  bus
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [7:0] DIV_LAST   = 8'(FRAME_DIV - 1);

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_active;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_next_frame;
    logic [7:0] r_div_cnt;

    logic       w_x_wrap;
    logic [9:0] w_x_next;
    logic [9:0] w_y_next;
    logic       w_fbe;
    logic       w_div_fire;
    logic [7:0] w_div_next;
    logic       w_step_fire;

`ifdef FRAME_STEP_EN
    logic r_step_s1;
    logic r_step_s2;
    logic r_step_d;
    logic r_step_pending;
    logic w_step_edge;
    logic w_pend_any;
    logic w_pending_next;
`else
    logic w_unused_step;
    assign w_unused_step = bus.step;
`endif

    always_comb begin
        w_x_wrap = (r_x == H_LAST);
        w_x_next = w_x_wrap ? 10'd0 : r_x + 10'd1;
        w_y_next = r_y;
        if (w_x_wrap) begin
            w_y_next = (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
        end
        // Frame boundary: first blanking line, decoded one cycle early
        w_fbe = (w_x_next == 10'd0) && (w_y_next == V_ACT_END);

        w_div_next = r_div_cnt;
        w_div_fire = 1'b0;
        if (w_fbe && !bus.pause) begin
            if (r_div_cnt == DIV_LAST) begin
                w_div_fire = 1'b1;
                w_div_next = 8'd0;
            end else begin
                w_div_next = r_div_cnt + 8'd1;
            end
        end

`ifdef FRAME_STEP_EN
        w_step_edge    = r_step_s2 & ~r_step_d;
        w_pend_any     = r_step_pending | w_step_edge;
        w_step_fire    = w_fbe & bus.pause & w_pend_any;
        // Pending step is consumed or discarded at every frame boundary
        w_pending_next = w_fbe ? 1'b0 : w_pend_any;
`else
        w_step_fire = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x          <= 10'd0;
            r_y          <= 10'd0;
            r_active     <= 1'b1;
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_next_frame <= 1'b0;
            r_div_cnt    <= 8'd0;
        end else begin
            r_x          <= w_x_next;
            r_y          <= w_y_next;
            r_active     <= (w_x_next < H_ACT_END) && (w_y_next < V_ACT_END);
            r_hsync      <= !((w_x_next >= H_SYNC_BEG) && (w_x_next < H_SYNC_END));
            r_vsync      <= !((w_y_next >= V_SYNC_BEG) && (w_y_next < V_SYNC_END));
            r_next_frame <= w_div_fire | w_step_fire;
            r_div_cnt    <= w_div_next;
        end
    end

`ifdef FRAME_STEP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step_s1      <= 1'b0;
            r_step_s2      <= 1'b0;
            r_step_d       <= 1'b0;
            r_step_pending <= 1'b0;
        end else begin
            r_step_s1      <= bus.step;
            r_step_s2      <= r_step_s1;
            r_step_d       <= r_step_s2;
            r_step_pending <= w_pending_next;
        end
    end
`endif

    assign bus.x          = r_x;
    assign bus.y          = r_y;
    assign bus.active     = r_active;
    assign bus.hsync      = r_hsync;
    assign bus.vsync      = r_vsync;
    assign bus.next_frame = r_next_frame;
endmodule

// File: tb/tb_vga_frame_timer.sv
// Directed bench for vga_frame_timer on a shrunken 16x11 raster (FBE at x=0,y=6,
// 176 clocks per frame); expects a step pulse only when FRAME_STEP_EN is defined.
module tb_vga_frame_timer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n;
    int   n_checks = 0;
    int   n_bad = 0;
    bit   step_en;

    vga_frame_timer_if if1 ();
    vga_frame_timer_if if3 ();

    vga_frame_timer #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .FRAME_DIV(1)
    ) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if1.master)
    );

    vga_frame_timer #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .FRAME_DIV(3)
    ) dut3 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if3.master)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s n=%0d got=%0d exp=%0d", tag, n, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    // Hand-derived raster: hsync low x=10..12, vsync low y=7..8, active x<8 && y<6
    task automatic check_timing();
        int ex;
        int ey;
        ex = n % 16;
        ey = (n / 16) % 11;
        check_val("x", 32'(if1.x), 32'(ex));
        check_val("y", 32'(if1.y), 32'(ey));
        check_val("active", 32'(if1.active), 32'(ex < 8 && ey < 6));
        check_val("hsync", 32'(if1.hsync), 32'(!(ex >= 10 && ex <= 12)));
        check_val("vsync", 32'(if1.vsync), 32'(!(ey >= 7 && ey <= 8)));
        check_val("nf1", 32'(if1.next_frame), 32'((n % 176) == 96));
    endtask

`ifdef FRAME_STEP_EN
    initial step_en = 1'b1;
`else
    initial step_en = 1'b0;
`endif

    initial begin
        if1.pause = 1'b0;
        if1.step  = 1'b0;
        if3.pause = 1'b0;
        if3.step  = 1'b0;
        n = 0;
        @(negedge clk);
        repeat (3) tick();
        check_val("rst_x", 32'(if1.x), 32'd0);
        check_val("rst_y", 32'(if1.y), 32'd0);
        check_val("rst_active", 32'(if1.active), 32'd1);
        check_val("rst_hsync", 32'(if1.hsync), 32'd1);
        check_val("rst_vsync", 32'(if1.vsync), 32'd1);
        check_val("rst_nf", 32'(if1.next_frame), 32'd0);
        check_val("rst_nf3", 32'(if3.next_frame), 32'd0);

        // Free run with pause window and a mid-frame pause glitch on the /3 instance
        rst_n = 1'b1;
        n = 0;
        while (n < 1900) begin
            check_timing();
            check_val("nf3", 32'(if3.next_frame), 32'(n == 448 || n == 976 || n == 1856));
            if3.pause = (n >= 1280 && n < 1600) || (n >= 1700 && n < 1720);
            tick();
        end

        // Reset mid-blanking at (4,6)
        while (n < 2036) tick();
        check_val("pre_rst_x", 32'(if1.x), 32'd4);
        check_val("pre_rst_y", 32'(if1.y), 32'd6);
        rst_n = 1'b0;
        tick();
        check_val("mrst_x", 32'(if1.x), 32'd0);
        check_val("mrst_y", 32'(if1.y), 32'd0);
        check_val("mrst_active", 32'(if1.active), 32'd1);
        check_val("mrst_hsync", 32'(if1.hsync), 32'd1);
        check_val("mrst_vsync", 32'(if1.vsync), 32'd1);
        check_val("mrst_nf", 32'(if1.next_frame), 32'd0);
        rst_n = 1'b1;
        n = 0;
        while (n <= 100) begin
            check_val("post_rst_nf", 32'(if1.next_frame), 32'(n == 96));
            tick();
        end

        // Paused with two step edges in one frame, then unpause
        while (n <= 640) begin
            check_val("step_nf", 32'(if1.next_frame), 32'((n == 272 && step_en) || n == 624));
            if1.step  = (n >= 120 && n < 130) || (n >= 140 && n < 150);
            if1.pause = !(n >= 460);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
